transport_send_arbiter: RTL

//  Shares one transportSend instance between two requesters: a control path (call setup/teardown

---
 rtl/tsend_pkg.sv | 21 ++
 rtl/tsend_audio_fifo.sv | 70 +++++++
 rtl/transport_send_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tsend_pkg.sv
// Shared types for the transportSend arbiter slice:
// command codes, arbiter FSM states and datapath width.
package tsend_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    CMD_IDLE   = 2'b00,
    CMD_DIAL   = 2'b01,
    CMD_HANGUP = 2'b10,
    CMD_CTRL   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_BUSY = 2'b10,
    ST_WAIT_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/tsend_audio_fifo.sv
// Small synchronous audio FIFO with registered ready and a
// saturating drop counter for samples refused while full.
module tsend_audio_fifo
  import tsend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              empty,
  output logic              ready,
  output logic [DATA_W-1:0] head,
  output logic [7:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        drop_q, drop_d;
  logic              ready_q, ready_d;
  logic              full, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    drop_d  = drop_q;
    if (push && full && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
    ready_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_q] <= din;
  end

  assign head     = mem_q[rd_q];
  assign ready    = ready_q;
  assign drop_cnt = drop_q;

endmodule

// File: rtl/transport_send_arbiter.sv
// Shares one transportSend between control and audio requesters.
// Define TSEND_ARB_FAIRNESS_EN to bound consecutive control grants.
module transport_send_arbiter
  import tsend_pkg::*;
#(
  parameter int AUDIO_DEPTH    = 4,
  parameter int BUSY_TIMEOUT   = 16,
  parameter int MAX_CTRL_BURST = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctrl_req,
  input  logic [1:0]        ctrl_cmd,
  input  logic [DATA_W-1:0] ctrl_arg,
  output logic              ctrl_ack,
  input  logic              audio_valid,
  input  logic [DATA_W-1:0] audio_sample,
  output logic              audio_ready,
  output logic [7:0]        audio_drop_cnt,
  output logic [1:0]        ts_cmd,
  output logic [DATA_W-1:0] ts_data,
  output logic              ts_send_data,
  input  logic              ts_busy,
  output logic              arb_busy,
  output logic              timeout_err
);

`ifdef TSEND_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int BW = $clog2(MAX_CTRL_BURST + 1);

  state_e            state_q;
  logic              aud_q;
  logic [TW-1:0]     wcnt_q;
  logic [BW-1:0]     burst_q;
  logic [1:0]        cmd_q;
  logic [DATA_W-1:0] data_q;
  logic              send_q, ack_q, terr_q;

  logic              fifo_empty, pop;
  logic [DATA_W-1:0] fifo_head;
  logic              ctrl_ok, aud_ok, force_aud;
  logic              pick_ctrl, pick_aud;

  assign pop = (state_q == ST_ISSUE) & aud_q;

  tsend_audio_fifo #(.DEPTH(AUDIO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (audio_valid),
    .din      (audio_sample),
    .pop      (pop),
    .empty    (fifo_empty),
    .ready    (audio_ready),
    .head     (fifo_head),
    .drop_cnt (audio_drop_cnt)
  );

  // An illegal 2'b00 command is never granted.
  assign ctrl_ok   = ctrl_req & (ctrl_cmd != CMD_IDLE);
  assign aud_ok    = ~fifo_empty;
  assign force_aud = FAIR & aud_ok &
                     (burst_q == BW'(MAX_CTRL_BURST));
  assign pick_ctrl = ctrl_ok & ~force_aud;
  assign pick_aud  = aud_ok & ~pick_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      aud_q   <= 1'b0;
      wcnt_q  <= '0;
      burst_q <= '0;
      cmd_q   <= CMD_IDLE;
      data_q  <= '0;
      send_q  <= 1'b0;
      ack_q   <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      cmd_q  <= CMD_IDLE;
      send_q <= 1'b0;
      ack_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!ts_busy && (pick_ctrl || pick_aud)) begin
            state_q <= ST_ISSUE;
            aud_q   <= pick_aud;
            if (pick_ctrl) begin
              cmd_q  <= ctrl_cmd;
              data_q <= ctrl_arg;
              ack_q  <= 1'b1;
            end else begin
              data_q <= fifo_head;
              send_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_BUSY;
          wcnt_q  <= '0;
          if (aud_q)
            burst_q <= '0;
          else if (burst_q != BW'(MAX_CTRL_BURST))
            burst_q <= burst_q + BW'(1);
        end
        ST_WAIT_BUSY: begin
          if (ts_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (wcnt_q == TW'(BUSY_TIMEOUT - 1)) begin
            // Packet presumed lost; no retry.
            terr_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wcnt_q <= wcnt_q + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!ts_busy)
            state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ctrl_ack     = ack_q;
  assign ts_cmd       = cmd_q;
  assign ts_data      = data_q;
  assign ts_send_data = send_q;
  assign arb_busy     = (state_q != ST_IDLE);
  assign timeout_err  = terr_q;

endmodule
